seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexes a DIGITS-wide hex value onto one shared 7-segment decoder input.
//  Each scan slot presents one nibble on digit_val and drives the matching active-low anode.
//  Sits directly upstream of the BCD-to-7-segment decoder: digit_val feeds the decoder's din.
//  New values load through a strobe and commit only at frame wrap, so the display never tears.
// PARAMETERS
//  DIGITS     4       number of digits scanned, 2..8
//  SCAN_DIV   100000  clk cycles per digit slot, >= 4
//  BLANK_CYC  1000    leading cycles of each slot with all anodes off (anti-ghosting), 1..SCAN_DIV-2
// PORTS
//  clk        in   1           system clock, rising edge
//  reset_n    in   1           asynchronous reset, active-low
//  data_in    in   4*DIGITS    hex value; nibble k drives digit k (digit 0 = least significant)
//  dp_in      in   DIGITS      decimal points; bit k goes with digit k, 1 = lit
//  data_vld   in   1           1-cycle load strobe for data_in/dp_in
//  digit_val  out  4           current nibble, to the decoder din
//  an         out  DIGITS      anode selects, active-low, at most one low
//  dp         out  1           decimal point of the current digit, active-high
//  digit_idx  out  clog2(DIGITS)  index of the current slot
//  ld_ack     out  1           1-cycle pulse, cycle after a load commits to the display
// BEHAVIOUR
//  Reset (async, reset_n=0): an all 1; digit_val, dp, digit_idx, ld_ack = 0.
//   Display register = 0, pending flag = 0, slot counter = 0, FSM = BLANK.
//  Slot counter cnt counts 0..SCAN_DIV-1. At cnt==SCAN_DIV-1: cnt->0 and digit_idx advances.
//   digit_idx wraps DIGITS-1 -> 0; that edge is the frame wrap.
//  FSM is two states, BLANK and SHOW.
//   BLANK: an all 1; moves to SHOW at cnt==BLANK_CYC-1.
//   SHOW: an[digit_idx]=0, others 1; moves to BLANK at cnt==SCAN_DIV-1.
//  digit_val and dp are registered and update on the same edge that digit_idx changes.
//   They stay stable for the whole slot, including BLANK.
//  Load: data_vld=1 captures data_in/dp_in into the pending register and sets the pending flag.
//   A later strobe before commit overwrites the pending value; the last strobe wins.
//  Commit happens only on the frame-wrap edge. If pending=1 or data_vld=1 on that edge:
//   display <= (data_vld ? data_in : pending value), pending <= 0, ld_ack = 1 the next cycle.
//   A strobe on the wrap edge therefore bypasses the pending register.
//  The digit-0 slot that starts at wrap already shows the newly committed value.
//  Without a pending value, wrap leaves the display unchanged and ld_ack stays 0.
//  digit_val = display[4*digit_idx +: 4]; no arithmetic and no width extension.
//  Reset mid-slot or mid-load: the pending value is discarded, the display returns to 0,
//   and scanning restarts at slot 0 in BLANK.
//  data_vld is ignored while reset_n=0.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: in SHOW, an[k] is held 1 when digit k is zero and every more
//   significant digit is zero, with k != 0. Digit 0 always lights. dp_in bit k=1 forces digit k lit.
//  LEADING_ZERO_BLANK_EN undefined: every digit lights in its SHOW phase regardless of value.
// TESTING  (bench: DIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
//  1 Reset: reset_n=0 -> an=4'b1111, digit_val=0, ld_ack=0.
//   After release: slot 0 BLANK for 2 cycles, then an=4'b1110 for 6 cycles.
//  2 Scan order: display 16'h3A7F.
//   -> digit_val sequence F,7,A,3 repeating, an 1110,1101,1011,0111.
//   -> each slot is 8 cycles with the first 2 all-off; digit_idx wraps 3->0.
//  3 Mid-frame load: data_vld with 16'h1234 during slot 1.
//   -> slots 1-3 still show the old value; wrap commits; ld_ack pulses once; slot 0 shows 4.
//  4 Double load/bypass: strobe 16'hAAAA in slot 2, then 16'h5555 on the wrap edge
//   -> display = 16'h5555, a single ld_ack pulse.
//  5 Reset mid-operation: reset_n=0 in slot 2 SHOW with a load pending.
//   -> an=1111 immediately (async); after release the display is 0 and no ld_ack occurs.
//  6 LEADING_ZERO_BLANK_EN: value 16'h0050
//   -> an[3] stays 1, an[2] stays 1, digits 1 and 0 light.
//   With dp_in=4'b1000, digit 3 lights showing 0. Value 16'h0000 -> only digit 0 lights.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Scanned multi-digit 7-segment driver: one nibble per slot, active-low anodes, tear-free frame-wrap commit.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 and dp-marked digits always light).
module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [4*DIGITS-1:0]         data_in,
    input  logic [DIGITS-1:0]           dp_in,
    input  logic                        data_vld,
    output logic [3:0]                  digit_val,
    output logic [DIGITS-1:0]           an,
    output logic                        dp,
    output logic [$clog2(DIGITS)-1:0]   digit_idx,
    output logic                        ld_ack
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r, idx_s;
    logic [4*DIGITS-1:0]   display_r, display_s, pend_data_r;
    logic [DIGITS-1:0]     disp_dp_r, disp_dp_s, pend_dp_r;
    logic                  pend_r;
    logic                  slot_end_s, wrap_s, commit_s;
    logic [DIGITS-1:0]     blank_s, an_s;
    logic [3:0]            digit_val_r;
    logic [DIGITS-1:0]     an_r;
    logic                  dp_r, ld_ack_r;

`ifdef LEADING_ZERO_BLANK_EN
    // A digit k>0 blanks when it and everything above it is zero, unless its dp is lit.
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] value,
                                                          input logic [DIGITS-1:0]   dps);
        logic [DIGITS-1:0] mask;
        logic              zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (value[4*k +: 4] == 4'h0) begin
                mask[k] = zero_above & ~dps[k];
            end else begin
                zero_above = 1'b0;
            end
        end
        return mask;
    endfunction
`endif

    // Slot timing, frame wrap and the display value that the next slot will use.
    always_comb begin
        slot_end_s = (cnt_r == CNT_W'(SCAN_DIV - 1));
        wrap_s     = slot_end_s && (idx_r == IDX_W'(DIGITS - 1));
        commit_s   = wrap_s && (pend_r || data_vld);
        display_s  = display_r;
        disp_dp_s  = disp_dp_r;
        idx_s      = idx_r;
        if (commit_s) begin
            display_s = data_vld ? data_in : pend_data_r;
            disp_dp_s = data_vld ? dp_in   : pend_dp_r;
        end else begin
            display_s = display_r;
        end
        if (wrap_s) begin
            idx_s = '0;
        end else if (slot_end_s) begin
            idx_s = idx_r + IDX_W'(1);
        end else begin
            idx_s = idx_r;
        end
    end

    // Next-state logic for the BLANK/SHOW phase within a slot.
    always_comb begin
        state_s = state_r;
        case (state_r)
            BLANK:   state_s = (cnt_r == CNT_W'(BLANK_CYC - 1)) ? SHOW : BLANK;
            SHOW:    state_s = slot_end_s ? BLANK : SHOW;
            default: state_s = BLANK;
        endcase
    end

    // Anode pattern for the upcoming cycle, registered below.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        blank_s = lead_zero_mask(display_s, disp_dp_s);
`else
        blank_s = '0;
`endif
        an_s = '1;
        for (int k = 0; k < DIGITS; k++) begin
            an_s[k] = ~((state_s == SHOW) && (idx_s == IDX_W'(k)) && !blank_s[k]);
        end
    end

    // State register, slot counter and digit index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= BLANK;
            cnt_r   <= '0;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= slot_end_s ? '0 : cnt_r + CNT_W'(1);
            idx_r   <= idx_s;
        end
    end

    // Pending load capture and display commit; a wrap-edge strobe goes straight to the display.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r      <= 1'b0;
            pend_data_r <= '0;
            pend_dp_r   <= '0;
            display_r   <= '0;
            disp_dp_r   <= '0;
        end else begin
            display_r <= display_s;
            disp_dp_r <= disp_dp_s;
            if (wrap_s) begin
                pend_r <= 1'b0;
            end else if (data_vld) begin
                pend_r      <= 1'b1;
                pend_data_r <= data_in;
                pend_dp_r   <= dp_in;
            end
        end
    end

    // Output registers; digit value and dp change only when the slot index does.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_val_r <= 4'h0;
            dp_r        <= 1'b0;
            an_r        <= '1;
            ld_ack_r    <= 1'b0;
        end else begin
            an_r     <= an_s;
            ld_ack_r <= commit_s;
            if (slot_end_s) begin
                digit_val_r <= display_s[{idx_s, 2'b00} +: 4];
                dp_r        <= disp_dp_s[idx_s];
            end
        end
    end

    assign digit_val = digit_val_r;
    assign an        = an_r;
    assign dp        = dp_r;
    assign digit_idx = idx_r;
    assign ld_ack    = ld_ack_r;

endmodule
